// File: rtl/sincos_pipe.sv
// Fixed-point sine/cosine pipeline: range reduction, parabolic estimate,
// 0.225 correction and clamp, nine enabled stages with valid/err sideband.
module sincos_pipe #(
    parameter int W    = 36,
    parameter int FRAC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic                mode,
    input  logic signed [W-1:0] angle,
    output logic                out_valid,
    output logic signed [W-1:0] result,
    output logic                range_err
);

    localparam int LAT = 9;

    function automatic logic signed [W-1:0] fx(input real c);
        real s;
        s = real'(longint'(1) << FRAC);
        return W'(longint'($floor(c * s + 0.5)));
    endfunction

    localparam logic signed [W-1:0] PI      = fx(3.14159265358979323846);
    localparam logic signed [W-1:0] TWO_PI  = fx(6.28318530717958647692);
    localparam logic signed [W-1:0] HALF_PI = fx(1.57079632679489661923);
    localparam logic signed [W-1:0] K1      = fx(1.27323954);
    localparam logic signed [W-1:0] K2      = fx(0.405284735);
    localparam logic signed [W-1:0] K3      = fx(0.225);
    localparam logic signed [W-1:0] ONE     = fx(1.0);

    localparam logic signed [2*W-1:0] RND_HALF =
        (2*W)'(1) << (FRAC - 1);

    // Adding half an LSB before the floor shift equals adding p[FRAC-1].
    function automatic logic signed [W-1:0] rnd(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        return W'((((2*W)'(a) * (2*W)'(b)) + RND_HALF) >>> FRAC);
    endfunction

    logic signed [W-1:0] r_s1_a;
    logic signed [W-1:0] r_s2_x;
    logic signed [W-1:0] r_s3_x2;
    logic signed [W-1:0] r_s3_t1;
    logic                r_s3_neg;
    logic signed [W-1:0] r_s4_t2;
    logic signed [W-1:0] r_s4_t1;
    logic                r_s4_neg;
    logic signed [W-1:0] r_s5_est;
    logic signed [W-1:0] r_s6_en2;
    logic signed [W-1:0] r_s6_est;
    logic signed [W-1:0] r_s7_d;
    logic signed [W-1:0] r_s7_est;
    logic signed [W-1:0] r_s8_c;
    logic signed [W-1:0] r_s8_est;
    logic signed [W-1:0] r_s9_res;
    logic [LAT-1:0]      r_vld;
    logic [LAT-1:0]      r_err;

    logic signed [W-1:0] w_a;
    logic                w_err;
    logic signed [W-1:0] w_x;
    logic signed [W-1:0] w_est;
    logic signed [W-1:0] w_e2;
    logic signed [W-1:0] w_en2;
    logic signed [W-1:0] w_r;
    logic signed [W-1:0] w_res;

    assign w_a   = angle + (mode ? HALF_PI : '0);
    assign w_err = (angle > TWO_PI) || (angle < -TWO_PI);

    assign w_x = (r_s1_a > PI)  ? r_s1_a - TWO_PI :
                 (r_s1_a < -PI) ? r_s1_a + TWO_PI :
                                  r_s1_a;

    assign w_est = r_s4_neg ? r_s4_t1 + r_s4_t2
                            : r_s4_t1 - r_s4_t2;

    assign w_e2  = rnd(r_s5_est, r_s5_est);
    assign w_en2 = r_s5_est[W-1] ? -w_e2 : w_e2;

    assign w_r   = r_s8_c + r_s8_est;
    assign w_res = (w_r > ONE)  ? ONE  :
                   (w_r < -ONE) ? -ONE :
                                  w_r;

    // Data path: every stage advances together on enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_a   <= '0;
            r_s2_x   <= '0;
            r_s3_x2  <= '0;
            r_s3_t1  <= '0;
            r_s3_neg <= 1'b0;
            r_s4_t2  <= '0;
            r_s4_t1  <= '0;
            r_s4_neg <= 1'b0;
            r_s5_est <= '0;
            r_s6_en2 <= '0;
            r_s6_est <= '0;
            r_s7_d   <= '0;
            r_s7_est <= '0;
            r_s8_c   <= '0;
            r_s8_est <= '0;
            r_s9_res <= '0;
        end else if (en) begin
            r_s1_a   <= w_a;
            r_s2_x   <= w_x;
            r_s3_x2  <= rnd(r_s2_x, r_s2_x);
            r_s3_t1  <= rnd(K1, r_s2_x);
            r_s3_neg <= r_s2_x[W-1];
            r_s4_t2  <= rnd(K2, r_s3_x2);
            r_s4_t1  <= r_s3_t1;
            r_s4_neg <= r_s3_neg;
            r_s5_est <= w_est;
            r_s6_en2 <= w_en2;
            r_s6_est <= r_s5_est;
            r_s7_d   <= r_s6_en2 - r_s6_est;
            r_s7_est <= r_s6_est;
            r_s8_c   <= rnd(K3, r_s7_d);
            r_s8_est <= r_s7_est;
            r_s9_res <= w_res;
        end
    end

    // Valid and range-error sideband, shifted in lockstep with the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            r_err <= '0;
        end else if (en) begin
            r_vld <= {r_vld[LAT-2:0], in_valid};
            r_err <= {r_err[LAT-2:0], w_err};
        end
    end

    assign out_valid = r_vld[LAT-1];
    assign range_err = r_err[LAT-1];
    assign result    = r_s9_res;

endmodule

// File: tb/tb_sincos_pipe.sv
// Scoreboard bench for sincos_pipe: directed angles, reset, stalls,
// wrap and range-error cases with a +/-3 LSB result tolerance.
module tb_sincos_pipe;
    localparam int W    = 36;
    localparam int FRAC = 16;
    localparam int TOL  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                in_valid;
    logic                mode;
    logic signed [W-1:0] angle;
    logic                out_valid;
    logic signed [W-1:0] result;
    logic                range_err;

    sincos_pipe #(.W(W), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .mode     (mode),
        .angle    (angle),
        .out_valid(out_valid),
        .result   (result),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint res;
        bit     err;
        bit     chk;
        int     edge_n;
        string  nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;
    bit   adv    = 1'b0;

    // Count enabled, out-of-reset edges; the monitor uses adv to know
    // whether the outputs were allowed to move since the last sample.
    always @(posedge clk) begin
        adv <= en && rst;
        if (en && rst) ecnt <= ecnt + 1;
    end

    logic signed [W-1:0] p_res = '0;
    logic                p_val = 1'b0;

    always @(negedge clk) begin
        exp_t   e;
        longint d;
        if (!rst) begin
            p_res = '0;
            p_val = 1'b0;
        end else if (adv) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got res=%0d err=%0b at edge %0d",
                             result, range_err, ecnt);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if (ecnt != e.edge_n) begin
                        errors++;
                        $display("FAIL latency_%s got edge %0d exp edge %0d",
                                 e.nm, ecnt, e.edge_n);
                    end
                    checks++;
                    if (range_err != e.err) begin
                        errors++;
                        $display("FAIL err_%s got %0b exp %0b",
                                 e.nm, range_err, e.err);
                    end
                    if (e.chk) begin
                        checks++;
                        d = longint'(result) - e.res;
                        if (d > TOL || d < -TOL) begin
                            errors++;
                            $display("FAIL res_%s got %0d exp %0d",
                                     e.nm, result, e.res);
                        end
                    end
                end
            end
            p_res = result;
            p_val = out_valid;
        end else begin
            checks++;
            if (result !== p_res || out_valid !== p_val) begin
                errors++;
                $display("FAIL hold got res=%0d v=%0b exp res=%0d v=%0b",
                         result, out_valid, p_res, p_val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input bit v, input longint ang, input bit m,
                        input longint er, input bit e, input bit c,
                        input string nm);
        exp_t x;
        en       = 1'b1;
        in_valid = v;
        angle    = W'(ang);
        mode     = m;
        if (v) begin
            x.res    = er;
            x.err    = e;
            x.chk    = c;
            x.edge_n = ecnt + 9;
            x.nm     = nm;
            q.push_back(x);
        end
        tick();
    endtask

    task automatic sin_s(input longint ang, input longint er,
                         input string nm);
        send(1'b1, ang, 1'b0, er, 1'b0, 1'b1, nm);
    endtask

    task automatic cos_s(input longint ang, input longint er,
                         input string nm);
        send(1'b1, ang, 1'b1, er, 1'b0, 1'b1, nm);
    endtask

    task automatic bubble();
        send(1'b0, 64'd123456, 1'b1, 0, 1'b0, 1'b0, "bubble");
    endtask

    // Inputs carry a live-looking sample while en is low; it must be ignored.
    task automatic stall(input int k);
        en       = 1'b0;
        in_valid = 1'b1;
        angle    = W'(64'd77777);
        mode     = 1'b0;
        repeat (k) tick();
    endtask

    task automatic chk_rst(input string nm);
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || range_err !== 1'b0) begin
            errors++;
            $display("FAIL %s got v=%0b res=%0d err=%0b exp 0/0/0",
                     nm, out_valid, result, range_err);
        end
    endtask

    initial begin
        int n;
        rst      = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        angle    = '0;
        repeat (2) tick();
        chk_rst("reset_state");
        rst = 1'b1;
        tick();

        // Reset with five samples in flight; none may emerge.
        repeat (5) sin_s(102944, 65536, "stale");
        rst = 1'b0;
        q.delete();
        #1;
        chk_rst("reset_midstream");
        tick();
        rst = 1'b1;
        sin_s(102944, 65536, "rst_halfpi");
        repeat (3) bubble();

        sin_s(0,       0,      "sin_0");
        sin_s(34315,   32768,  "sin_pi6");
        sin_s(102944,  65536,  "sin_pi2");
        sin_s(205887,  0,      "sin_pi");
        sin_s(-102944, -65536, "sin_mpi2");

        cos_s(0, 65536, "alt_cos0a");
        sin_s(0, 0,     "alt_sin0a");
        cos_s(0, 65536, "alt_cos0b");
        sin_s(0, 0,     "alt_sin0b");
        cos_s(205887, -65536, "cos_pi");

        sin_s(308831,  -65536, "wrap_3pi2");
        sin_s(-308831, 65536,  "wrap_m3pi2");
        cos_s(411775,  65536,  "wrap_cos2pi");

        send(1'b1, 500000, 1'b0, 0, 1'b1, 1'b0, "range_err");
        bubble();
        sin_s(102944, 65536, "after_err");

        cos_s(0,       65536,  "st_cos0");
        sin_s(102944,  65536,  "st_pi2");
        sin_s(-102944, -65536, "st_mpi2");
        stall(4);
        sin_s(34315,   32768,  "st_pi6");
        sin_s(0,       0,      "st_0");
        cos_s(205887,  -65536, "st_cospi");
        repeat (5) bubble();
        stall(4);

        n = 0;
        while (q.size() != 0 && n < 60) begin
            bubble();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        repeat (12) bubble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sincos_pipe.md
# sincos_pipe

Parametrised fixed-point sine/cosine pipeline for the IK datapath's T-block. It accepts one signed angle per enabled cycle, performs single-step range reduction to [-π, π], and selects sin or cos per sample via a mode bit. The result comes from the parabolic estimate plus a 0.225 correction term. Every stage is registered and gated by a clock enable, and a valid bit travels with each sample.

## Interface
Parameters:
- W, default 36: data width of angle, result and all intermediates; signed two's complement.
- FRAC, default 16: fractional bits of every fixed-point value. W ≥ FRAC+5 is required.

Constants are localparams computed at elaboration as round(c·2^FRAC). At FRAC=16 they are:
- PI 205887
- TWO_PI 411775
- HALF_PI 102944
- K1 (1.27323954) 83443
- K2 (0.405284735) 26561
- K3 (0.225) 14746

Ports:
- clk, input, 1: clock; all state on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: clock enable. When low, every pipeline register, including valid bits, holds its value.
- in_valid, input, 1: angle and mode are a sample this cycle (sampled only when en=1).
- mode, input, 1: 0 = sin, 1 = cos.
- angle, input, W: signed radians, Q(W-FRAC).FRAC. Legal range is [-2π, 2π].
- out_valid, output, 1: result and range_err are valid.
- result, output, W: signed Q.FRAC sin/cos, clamped to [-2^FRAC, +2^FRAC].
- range_err, output, 1: the input angle was outside [-TWO_PI, +TWO_PI]; result is undefined for that sample.

## Operation
Every multiply uses the same product rounding:
- Take the full 2W-bit signed product p.
- Output p[W+FRAC-1:FRAC] + p[FRAC-1], i.e. round half up on the first dropped bit.
- Intermediate adds and subtracts are W-bit and wrap.

Stages, each a register advanced only when en=1:
1. **S1:**
   - a = angle + (mode ? HALF_PI : 0).
   - err = (angle > TWO_PI) || (angle < -TWO_PI).
2. **S2:** wrap.
   - If a > PI, x = a − TWO_PI.
   - If a < −PI, x = a + TWO_PI.
   - Otherwise x = a.
3. **S3:** x2 = rnd(x·x); t1 = rnd(K1·x).
4. **S4:** t2 = rnd(K2·x2); t1 is delayed.
5. **S5:** est = x<0 ? t1 + t2 : t1 − t2. Uses the sign of x delayed to align with t1 and t2.
6. **S6:** e2 = rnd(est·est); en2 = est<0 ? −e2 : e2.
7. **S7:** d = en2 − est (est delayed to align).
8. **S8:** c = rnd(K3·d).
9. **S9:** r = c + est (est delayed). result = clamp(r, −2^FRAC, +2^FRAC).

Valid and error sideband:
- in_valid and err travel in a 9-deep shift register alongside the data.
- out_valid and range_err are the final stage outputs.
- Data registers advance on en regardless of valid. Bubbles carry don't-care data with valid=0.

## Timing
- Latency is exactly 9 enabled cycles. A sample presented with in_valid=1 on enabled edge N appears with out_valid=1 after enabled edge N+8, i.e. it is visible in the cycle following that edge.
- Throughput: one sample per enabled cycle with no back-pressure. Downstream stalls by deasserting en.
- en low for k cycles stretches latency by k cycles. Outputs are held stable during the stall, with no duplication and no loss.
- Reset (rst=0), at any time and asynchronously:
  - all data registers, valid bits and err bits clear;
  - out_valid=0, result=0, range_err=0;
  - in-flight samples are discarded.
- After rst rises, the first sample accepted at the first enabled edge emerges after 9 enabled edges. out_valid stays 0 until then.
- Boundaries:
  - a = exactly ±PI is not wrapped.
  - Cos with angle near 2π: a up to 2π+π/2 wraps into range.
  - Clamp activates only when |r| > 2^FRAC.
  - Mixed sin/cos samples may alternate every cycle.

## Test plan
Tolerance is ±3 LSB at W=36, FRAC=16.
- **Reset and latency:** assert rst low mid-stream with 5 samples in flight, release, then feed angle=102944 (π/2), mode=0.
  - out_valid must stay 0 until exactly 9 enabled edges after acceptance.
  - result must be 65536.
  - No stale samples may emerge.
- **Sin points:** angles 0, 34315 (π/6), 102944, 205887 (π), −102944, streamed back to back.
  - Results 0, 32768, 65536, 0, −65536 on consecutive cycles.
- **Cos and alternation:** alternate mode 1/0 on angle 0.
  - Results alternate 65536 / 0.
  - Cos of 205887 gives −65536.
- **Wrap:** angle 308831 (3π/2), mode 0 → −65536. Angle −308831 → 65536. Angle 411775 with mode 1 → 65536.
- **Stall:** stream 6 samples and drop en for 4 cycles mid-stream, including while out_valid=1.
  - The output sequence is identical to the unstalled run.
  - result and out_valid are held constant during the stall.
- **Range error:** angle 500000 → out_valid=1, range_err=1. The next legal sample has range_err=0. A bubble (in_valid=0) in between produces out_valid=0 for that slot.
